// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 multiplier sequencer: state encoding and
// the helper that sizes the digit index.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A single-digit multiplier still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_sequencer_digit_counter.sv
// Radix-4 digit index counter: synchronous clear has priority over enable,
// and last flags the final digit (N-1).
module digit_counter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] idx,
    output logic         last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (enable) begin
            idx <= idx + W'(1);
        end
    end

    assign last = (idx == W'(N - 1));

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for a radix-4 (Booth) multiplier datapath: latches operands,
// strobes load, steps one digit per cycle, then holds the result until taken.
// Optional feature macro: MULT_SEQ_PERF_CNT_EN adds the op_count output.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    localparam int N      = Y_WIDTH / 2,
    localparam int IDX_W  = idx_width(Y_WIDTH / 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [Y_WIDTH-1:0] y_in,
    input  logic               abort,
    output logic [X_WIDTH-1:0] x_hold,
    output logic [Y_WIDTH-1:0] y_hold,
    output logic               load,
    output logic               step,
    output logic               first_digit,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               answering,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef MULT_SEQ_PERF_CNT_EN
    output logic [15:0]        op_count,
`endif
    output logic               busy
);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   last_digit;
    logic   cnt_clear;
    logic   cnt_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = LOAD;
            LOAD: state_next = RUN;
            RUN:  if (last_digit) state_next = DONE;
            DONE: if (out_ready) state_next = in_valid ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
        // Abort outranks everything except when already idle.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Operands are taken only on a transition into LOAD from IDLE or DONE.
    assign accept = (state_next == LOAD) && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (accept) begin
            x_hold <= x_in;
            y_hold <= y_in;
        end
    end

    // Clearing on the last digit leaves the index at 0 through DONE and IDLE.
    assign cnt_enable = (state == RUN);
    assign cnt_clear  = (state != RUN) || abort || last_digit;

    digit_counter #(
        .N (N),
        .W (IDX_W)
    ) u_digit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .idx    (digit_idx),
        .last   (last_digit)
    );

    // Every strobe is a pure decode of registered state, keeping in_valid off
    // all output paths; in_ready alone looks at out_ready.
    assign load        = (state == LOAD);
    assign step        = (state == RUN);
    assign answering   = (state == RUN);
    assign first_digit = (state == RUN) && (digit_idx == '0);
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign in_ready    = (state == IDLE) || ((state == DONE) && out_ready);

`ifdef MULT_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if ((state == DONE) && out_ready && !abort) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (X_WIDTH=Y_WIDTH=8, four digits): vector
// table plus hand-written latency, hold, abort and async-reset sequences.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic       abort;
    logic [7:0] x_hold;
    logic [7:0] y_hold;
    logic       load;
    logic       step;
    logic       first_digit;
    logic [1:0] digit_idx;
    logic       answering;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef MULT_SEQ_PERF_CNT_EN
    logic [15:0] op_count;
    int unsigned exp_ops;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_sequencer #(
        .X_WIDTH (8),
        .Y_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x_in        (x_in),
        .y_in        (y_in),
        .abort       (abort),
        .x_hold      (x_hold),
        .y_hold      (y_hold),
        .load        (load),
        .step        (step),
        .first_digit (first_digit),
        .digit_idx   (digit_idx),
        .answering   (answering),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef MULT_SEQ_PERF_CNT_EN
        .op_count    (op_count),
`endif
        .busy        (busy)
    );

    typedef struct {
        logic       iv, ordy, ab;
        logic [7:0] x, y;
        logic       ld, stp, fd;
        logic [1:0] idx;
        logic       ov, bsy, rdy;
        logic [7:0] xh, yh;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, ordy, ab, input logic [7:0] x, y,
                                input logic ld, stp, fd, input logic [1:0] idx,
                                input logic ov, bsy, rdy, input logic [7:0] xh, yh);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.ab = ab; v.x = x; v.y = y;
        v.ld = ld; v.stp = stp; v.fd = fd; v.idx = idx;
        v.ov = ov; v.bsy = bsy; v.rdy = rdy; v.xh = xh; v.yh = yh;
        return v;
    endfunction

    task automatic check_outs(input string tag, input logic ld, stp, fd, input logic [1:0] idx,
                              input logic ov, bsy, rdy, input logic [7:0] xh, yh);
        chk({tag, ".load"}, 32'(load), 32'(ld));
        chk({tag, ".step"}, 32'(step), 32'(stp));
        chk({tag, ".answering"}, 32'(answering), 32'(stp));
        chk({tag, ".first_digit"}, 32'(first_digit), 32'(fd));
        chk({tag, ".digit_idx"}, 32'(digit_idx), 32'(idx));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".x_hold"}, 32'(x_hold), 32'(xh));
        chk({tag, ".y_hold"}, 32'(y_hold), 32'(yh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair from IDLE; returns after the acceptance edge.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1; x_in = x; y_in = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 20 && !out_valid; k++) tick();
        if (!out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL %s: out_valid timeout, got 0, expected 1", tag);
        end
    endtask

    initial begin
        // iv ordy ab  x      y       ld stp fd idx ov bsy rdy xh     yh
        tbl[0]  = mk(1, 0, 0, 8'h05, 8'h03, 1, 0, 0, 0, 0, 1, 0, 8'h05, 8'h03);
        tbl[1]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 0, 8'h05, 8'h03);
        tbl[2]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 0, 8'h05, 8'h03);
        tbl[3]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2, 0, 1, 0, 8'h05, 8'h03);
        tbl[4]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 3, 0, 1, 0, 8'h05, 8'h03);
        tbl[5]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h05, 8'h03);
        tbl[6]  = mk(1, 0, 0, 8'h99, 8'h99, 0, 0, 0, 0, 1, 1, 0, 8'h05, 8'h03);
        tbl[7]  = mk(1, 0, 0, 8'h99, 8'h99, 0, 0, 0, 0, 1, 1, 0, 8'h05, 8'h03);
        tbl[8]  = mk(1, 1, 0, 8'h7F, 8'hAA, 1, 0, 0, 0, 0, 1, 0, 8'h7F, 8'hAA);
        tbl[9]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 0, 8'h7F, 8'hAA);
        tbl[10] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 0, 8'h7F, 8'hAA);
        tbl[11] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2, 0, 1, 0, 8'h7F, 8'hAA);
        tbl[12] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 3, 0, 1, 0, 8'h7F, 8'hAA);
        tbl[13] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h7F, 8'hAA);
        tbl[14] = mk(0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h7F, 8'hAA);
        tbl[15] = mk(1, 0, 1, 8'h11, 8'h22, 1, 0, 0, 0, 0, 1, 0, 8'h11, 8'h22);
        tbl[16] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 1, 0, 8'h11, 8'h22);
        tbl[17] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 0, 8'h11, 8'h22);
        tbl[18] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 2, 0, 1, 0, 8'h11, 8'h22);
        tbl[19] = mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h11, 8'h22);
        tbl[20] = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h11, 8'h22);

        rst = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; abort = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
`ifdef MULT_SEQ_PERF_CNT_EN
        exp_ops = 0;
        chk("reset.op_count", 32'(op_count), 32'd0);
`endif
        rst = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; abort = tbl[i].ab;
            x_in = tbl[i].x; y_in = tbl[i].y;
            tick();
            check_outs($sformatf("vec%0d", i), tbl[i].ld, tbl[i].stp, tbl[i].fd, tbl[i].idx,
                       tbl[i].ov, tbl[i].bsy, tbl[i].rdy, tbl[i].xh, tbl[i].yh);
        end
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
`ifdef MULT_SEQ_PERF_CNT_EN
        exp_ops = 2;
        chk("table.op_count", 32'(op_count), 32'(exp_ops));
`endif

        // Latency: load at +1, four steps, out_valid at +6.
        begin
            int steps;
            int ov_at;
            steps = 0; ov_at = -1;
            start_op(8'h05, 8'h03);
            chk("lat.load_at_1", 32'(load), 32'd1);
            for (int k = 2; k <= 12 && ov_at < 0; k++) begin
                tick();
                if (step) steps++;
                if (out_valid) ov_at = k;
            end
            chk("lat.steps", 32'(steps), 32'd4);
            chk("lat.out_valid_at", 32'(ov_at), 32'd6);
        end

        // Result held in DONE while the consumer stalls.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.x_hold", 32'(x_hold), 32'h05);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("done.in_ready_comb", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0;
        chk("done.to_idle", 32'(busy), 32'd0);
`ifdef MULT_SEQ_PERF_CNT_EN
        exp_ops++;
        chk("done.op_count", 32'(op_count), 32'(exp_ops));
`endif

        // Abort in DONE beats the completing handshake.
        start_op(8'h33, 8'h44);
        wait_done("abort_done");
        abort = 1'b1; out_ready = 1'b1; in_valid = 1'b1; x_in = 8'hEE; y_in = 8'hEE;
        tick();
        abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("abort_done.busy", 32'(busy), 32'd0);
        chk("abort_done.out_valid", 32'(out_valid), 32'd0);
        chk("abort_done.x_hold", 32'(x_hold), 32'h33);
`ifdef MULT_SEQ_PERF_CNT_EN
        chk("abort_done.op_count", 32'(op_count), 32'(exp_ops));
`endif

        // Asynchronous reset while in RUN.
        start_op(8'h5A, 8'hA5);
        tick();
        tick();
        chk("arst.pre_step", 32'(step), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("arst", 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        chk("arst.after_busy", 32'(busy), 32'd0);
        chk("arst.after_load", 32'(load), 32'd0);
`ifdef MULT_SEQ_PERF_CNT_EN
        exp_ops = 0;
        chk("arst.op_count", 32'(op_count), 32'd0);

        // Counter wraps 0xFFFF -> 0 after 65536 completions.
        for (int i = 0; i < 65537; i++) begin
            start_op(8'h01, 8'h01);
            wait_done("wrap");
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("wrap.op_count", 32'(op_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter X_WIDTH, default 8: multiplicand width.
REQ-002 SHALL have parameter Y_WIDTH, default 8: multiplier width; even, at least 2; digit count N = Y_WIDTH/2.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: sequencer accepts operands.
REQ-007 SHALL have port x_in, input, X_WIDTH: multiplicand.
REQ-008 SHALL have port y_in, input, Y_WIDTH: multiplier.
REQ-009 SHALL have port abort, input, 1: cancel the current operation.
REQ-010 SHALL have port x_hold, output, X_WIDTH: latched multiplicand to the datapath.
REQ-011 SHALL have port y_hold, output, Y_WIDTH: latched multiplier to the datapath.
REQ-012 SHALL have port load, output, 1: one-cycle load strobe to the datapath registers.
REQ-013 SHALL have port step, output, 1: advance the shift register and recoder by one radix-4 digit.
REQ-014 SHALL have port first_digit, output, 1: force recoder carry-in to 0.
REQ-015 SHALL have port digit_idx, output, $clog2(N) (minimum 1 bit): index of the current digit.
REQ-016 SHALL have port answering, output, 1: a partial product is valid this cycle.
REQ-017 SHALL have port out_valid, output, 1: operation complete.
REQ-018 SHALL have port out_ready, input, 1: completion acknowledged.
REQ-019 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-020 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-021 SHALL assert in_ready in IDLE, and in DONE when out_ready=1; deassert it otherwise.
REQ-022 SHALL, on in_valid&&in_ready, capture x_in and y_in into x_hold and y_hold and enter LOAD on the next edge.
REQ-023 SHALL assert load for exactly one cycle in LOAD, then enter RUN with digit_idx=0.
REQ-024 SHALL, in RUN, assert step and answering every cycle; first_digit=1 only when digit_idx=0; digit_idx increments each cycle.
REQ-025 SHALL leave RUN for DONE after the cycle with digit_idx=N-1; total latency from acceptance to out_valid is N+2 cycles.
REQ-026 SHALL hold out_valid=1 in DONE until out_ready=1; x_hold and y_hold stay stable meanwhile.
REQ-027 SHALL, in DONE with out_ready=1: go to LOAD if in_valid=1 (back-to-back operation, operands captured), else go to IDLE.
REQ-028 SHALL give abort priority over all other events: any non-IDLE state goes to IDLE on the next edge, with no out_valid and digit_idx cleared.
REQ-029 SHALL ignore abort in IDLE; abort together with in_valid in IDLE accepts the operands.
REQ-030 SHALL make load, step, answering and first_digit mutually consistent: step=answering; never asserted together with load.
REQ-031 SHALL drive all outputs from registers or state decode only; no combinational path from in_valid to any output except in_ready, which uses out_ready only.

Reset
REQ-032 SHALL, while rst=0, force state=IDLE, digit_idx=0, x_hold=0, y_hold=0, load=step=answering=first_digit=out_valid=busy=0 and in_ready=1.
REQ-033 SHALL, on reset asserted mid-operation, discard the operation; the first cycle after release is IDLE.

Configuration
REQ-034 SHALL, with MULT_SEQ_PERF_CNT_EN defined, add output op_count[15:0]: counts completed handshakes (out_valid&&out_ready), wraps 0xFFFF->0, excludes aborts, resets to 0.
REQ-035 SHALL, without MULT_SEQ_PERF_CNT_EN, omit the op_count port and its logic entirely.

Structure
REQ-036 SHALL place the state enum (IDLE/LOAD/RUN/DONE) and the function for the digit-count width in shared package mult_pkg.
REQ-037 SHALL implement the digit index in sub-module digit_counter (clear, enable, terminal-count flag at N-1).

Verification
REQ-038 SHALL cover: X=8,Y=8, x=0x05,y=0x03 accepted -> load at cycle+1, step for 4 cycles with digit_idx 0..3, out_valid at cycle+6.
REQ-039 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, x_hold=0x05 stable, in_ready=0.
REQ-040 SHALL cover: in DONE, out_ready=1 with in_valid=1 (x=0x7F,y=0xAA) -> next state LOAD, y_hold=0xAA, no IDLE cycle.
REQ-041 SHALL cover: abort at digit_idx=2 -> IDLE next cycle, out_valid never asserted, op_count unchanged.
REQ-042 SHALL cover: rst pulled low asynchronously during RUN -> outputs take reset values before the next clk edge.
REQ-043 SHALL cover, with MULT_SEQ_PERF_CNT_EN: 65537 completed operations -> op_count=1.
